add_arb: RTL

- Sequences and shares one add_fsm adder datapath between N requesters.
- Accepts per-requester operand pairs and picks one winner per operation.
- Drives the adder's go/a/b inputs, waits a fixed adder latency, captures the result, and returns it to the winner with a one-cycle done pulse.
- Sits between client logic and a single add_fsm instance.

---
 rtl/add_pkg.sv | 19 +
 rtl/add_arb_pick.sv | 47 ++++
 rtl/add_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/add_pkg.sv
// Shared types and constants for the add_arb adder-sharing slice.
// Optional feature macro: ADD_ARB_RR_EN (round-robin arbitration).
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned ADD_W = 6;

    // Counter must hold the value ADD_LAT itself.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/add_arb_pick.sv
// Combinational winner select for add_arb.
// Optional feature macro: ADD_ARB_RR_EN -- round-robin search starting at ptr;
// otherwise fixed priority with the lowest index winning.
module add_arb_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
`ifdef ADD_ARB_RR_EN
    input  logic [PW-1:0] ptr,
`endif
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

`ifdef ADD_ARB_RR_EN
    int unsigned pos;
`endif
    logic found;

    // First requester encountered in search order wins; one-hot plus index.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
`ifdef ADD_ARB_RR_EN
        pos   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
                found    = 1'b1;
            end
        end
`else
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                idx    = PW'(k);
                found  = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/add_arb.sv
// Shares one add_fsm adder between N requesters: pick a winner, issue the
// operands, wait ADD_LAT cycles, return add_result with a one-cycle done.
// Optional feature macro: ADD_ARB_RR_EN (round-robin instead of fixed priority).
module add_arb
    import add_pkg::*;
#(
    parameter int unsigned N       = 2,
    parameter int unsigned W       = ADD_W,
    parameter int unsigned ADD_LAT = 4
) (
    input  logic           CLK,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_flat,
    input  logic [N*W-1:0] b_flat,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic [W-1:0]   result,
    output logic           busy,
    output logic           add_go,
    output logic [W-1:0]   add_a,
    output logic [W-1:0]   add_b,
    input  logic [W-1:0]   add_result
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = cnt_width(ADD_LAT);

    state_t        state, nxt;
    logic [PW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  pick_gnt;
    logic [PW-1:0] pick_idx;
    logic [N-1:0]  sel;

`ifdef ADD_ARB_RR_EN
    logic [PW-1:0] rr;
`endif

    add_arb_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req (req),
`ifdef ADD_ARB_RR_EN
        .ptr (rr),
`endif
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign sel = N'(1) << idx;

    // State register plus operand latch, latency counter and result capture.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            cnt    <= '0;
            result <= '0;
            add_a  <= '0;
            add_b  <= '0;
`ifdef ADD_ARB_RR_EN
            rr     <= '0;
`endif
        end else begin
            state <= nxt;
            case (state)
                ST_IDLE: begin
                    if (|pick_gnt) begin
                        idx   <= pick_idx;
                        add_a <= a_flat[pick_idx*W +: W];
                        add_b <= b_flat[pick_idx*W +: W];
                    end
                end
                ST_ISSUE: cnt <= CW'(ADD_LAT);
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1))
                        result <= add_result;
                end
                ST_DONE: begin
`ifdef ADD_ARB_RR_EN
                    if (idx == PW'(N - 1))
                        rr <= '0;
                    else
                        rr <= idx + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        nxt    = state;
        add_go = 1'b0;
        busy   = 1'b1;
        grant  = '0;
        done   = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (|pick_gnt)
                    nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                add_go = 1'b1;
                grant  = sel;
                nxt    = ST_WAIT;
            end
            ST_WAIT: begin
                grant = sel;
                if (cnt == CW'(1))
                    nxt = ST_DONE;
            end
            ST_DONE: begin
                grant = sel;
                done  = sel;
                nxt   = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

endmodule
